match_confirm: RTL and testbench

- Sits directly downstream of the HSV comparator; consumes its registered `similar_flag`.
- Turns the per-sample similarity flag into a debounced "colour matched" decision, with confirmation and release hysteresis.
- Produces a one-cycle match event, a saturating match counter and an LED status drive for the board.
- Single clock domain, same clock as the comparator.

---
 rtl/match_confirm.sv | 210 +++++++++++++++++++++
 tb/tb_match_confirm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_confirm.sv
// match_confirm: debounces the comparator similarity flag into a "colour matched"
// decision with confirm/release hysteresis. It also drives a one-cycle match
// pulse, a saturating match counter and a status LED.
// Optional beep output is enabled by defining MATCH_BEEP_EN.
module match_confirm #(
   parameter int SAMPLE_DIV  = 500000,
   parameter int CONFIRM_N   = 8,
   parameter int RELEASE_N   = 8,
   parameter int BLINK_DIV   = 12500000,
`ifdef MATCH_BEEP_EN
   parameter int BEEP_CYCLES = 5000000,
`endif
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             similar_flag,
   input  logic             clear,
   output logic             matched,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_cnt,
`ifdef MATCH_BEEP_EN
   output logic             beep,
`endif
   output logic             led
);

   localparam int RUN_MAX = (CONFIRM_N > RELEASE_N) ? CONFIRM_N : RELEASE_N;
   localparam int DIV_W   = $clog2(SAMPLE_DIV);
   localparam int RUN_W   = $clog2(RUN_MAX + 1);
   localparam int BLINK_W = $clog2(BLINK_DIV);

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [RUN_W-1:0]   CONFIRM_V  = RUN_W'(CONFIRM_N);
   localparam logic [RUN_W-1:0]   RELEASE_V  = RUN_W'(RELEASE_N);

   typedef enum logic [1:0] {IDLE, CONFIRM, MATCHED, RELEASE} state_t;

   state_t             state;
   state_t             next_state;
   logic [RUN_W-1:0]   run;
   logic [RUN_W-1:0]   next_run;
   logic               enter_match;
   logic [DIV_W-1:0]   div;
   logic [BLINK_W-1:0] blink;
   logic               tick;

   assign tick = (div == DIV_LAST);

   // Sample divider: free-running 0..SAMPLE_DIV-1, tick on the last count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // State and consecutive-sample run counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         run   <= '0;
      end else begin
         state <= next_state;
         run   <= next_run;
      end
   end

   // Next-state logic; the flag only matters on sample ticks
   always_comb begin
      next_state  = state;
      next_run    = run;
      enter_match = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (similar_flag) begin
                  if (CONFIRM_N == 1) begin
                     next_state  = MATCHED;
                     next_run    = '0;
                     enter_match = 1'b1;
                  end else begin
                     next_state = CONFIRM;
                     next_run   = RUN_W'(1);
                  end
               end
            end
            CONFIRM: begin
               if (similar_flag) begin
                  if (run + 1'b1 == CONFIRM_V) begin
                     next_state  = MATCHED;
                     next_run    = '0;
                     enter_match = 1'b1;
                  end else begin
                     next_run = run + 1'b1;
                  end
               end else begin
                  next_state = IDLE;
                  next_run   = '0;
               end
            end
            MATCHED: begin
               if (!similar_flag) begin
                  if (RELEASE_N == 1) begin
                     next_state = IDLE;
                     next_run   = '0;
                  end else begin
                     next_state = RELEASE;
                     next_run   = RUN_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (!similar_flag) begin
                  if (run + 1'b1 == RELEASE_V) begin
                     next_state = IDLE;
                     next_run   = '0;
                  end else begin
                     next_run = run + 1'b1;
                  end
               end else begin
                  next_state = MATCHED;
                  next_run   = '0;
               end
            end
            default: begin
               next_state = IDLE;
               next_run   = '0;
            end
         endcase
      end
   end

   // Registered match status, entry pulse and saturating counter (clear wins)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         matched     <= 1'b0;
         match_pulse <= 1'b0;
         match_cnt   <= '0;
      end else begin
         matched     <= (next_state == MATCHED) || (next_state == RELEASE);
         match_pulse <= enter_match;
         if (clear) begin
            match_cnt <= '0;
         end else if (enter_match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
         end
      end
   end

   // LED: off when idle, blinking while confirming (restarting on entry), on when matched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink <= '0;
         led   <= 1'b0;
      end else begin
         case (next_state)
            CONFIRM: begin
               if (state != CONFIRM) begin
                  blink <= '0;
                  led   <= 1'b0;
               end else if (blink == BLINK_LAST) begin
                  blink <= '0;
                  led   <= ~led;
               end else begin
                  blink <= blink + 1'b1;
               end
            end
            MATCHED, RELEASE: begin
               blink <= '0;
               led   <= 1'b1;
            end
            default: begin
               blink <= '0;
               led   <= 1'b0;
            end
         endcase
      end
   end

`ifdef MATCH_BEEP_EN
   localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
   localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

   logic [BEEP_W-1:0] beep_cnt;

   // Beep starts with the match pulse and lasts BEEP_CYCLES; a new match restarts it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep     <= 1'b0;
         beep_cnt <= '0;
      end else if (enter_match) begin
         beep     <= 1'b1;
         beep_cnt <= '0;
      end else if (beep) begin
         if (beep_cnt == BEEP_LAST) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
         end else begin
            beep_cnt <= beep_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_match_confirm.sv
// tb_match_confirm: randomized and directed flag patterns for match_confirm,
// checked cycle by cycle against a run-length reference model via a scoreboard queue.
module tb_match_confirm;

   localparam int SD = 4;
   localparam int CN = 3;
   localparam int RN = 2;
   // Short blink period so the LED visibly toggles within one confirmation window
   localparam int BD = 3;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          similar_flag;
   logic          clear;
   logic          matched;
   logic          match_pulse;
   logic [CW-1:0] match_cnt;
   logic          led;
`ifdef MATCH_BEEP_EN
   logic          beep;
`endif

   match_confirm #(
      .SAMPLE_DIV(SD),
      .CONFIRM_N (CN),
      .RELEASE_N (RN),
      .BLINK_DIV (BD),
      .CNT_W     (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .similar_flag(similar_flag),
      .clear       (clear),
      .matched     (matched),
      .match_pulse (match_pulse),
      .match_cnt   (match_cnt),
`ifdef MATCH_BEEP_EN
      .beep        (beep),
`endif
      .led         (led)
   );

   typedef struct {
      logic m;
      logic p;
      int   cnt;
      logic l;
      int   cyc;
   } exp_t;

   exp_t expQ[$];

   int nChecks = 0;
   int nFails  = 0;
   int nPulses = 0;

   // Reference model: counts of consecutive agreeing samples, not states
   int  cyc;
   bit  mMatched;
   int  ones;
   int  zeros;
   int  age;
   int  cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string name, input int act, input int exp, input int c);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s cyc=%0d actual=%0d expected=%0d", name, c, act, exp);
      end
   endtask

   task automatic modelReset();
      cyc = 0; mMatched = 0; ones = 0; zeros = 0; age = 0; cnt = 0;
   endtask

   // Advance the model by one clock cycle and queue the outputs expected after the edge
   task automatic modelStep(input bit f, input bit clr);
      exp_t e;
      bit   tick;
      bit   pulse;
      bit   justEntered;
      bit   confirming;
      pulse = 0;
      justEntered = 0;
      tick = (cyc % SD) == (SD - 1);
      if (tick) begin
         if (!mMatched) begin
            if (f) begin
               ones++;
               if (ones == 1) justEntered = 1;
               if (ones == CN) begin
                  mMatched = 1;
                  ones = 0;
                  zeros = 0;
                  pulse = 1;
               end
            end else begin
               ones = 0;
            end
         end else begin
            if (!f) begin
               zeros++;
               if (zeros == RN) begin
                  mMatched = 0;
                  zeros = 0;
               end
            end else begin
               zeros = 0;
            end
         end
      end
      confirming = !mMatched && (ones > 0);
      if (confirming) age = justEntered ? 0 : age + 1;
      if (clr) cnt = 0;
      else if (pulse && cnt < CNT_MAX) cnt++;
      if (pulse) nPulses++;
      e.m   = mMatched;
      e.p   = pulse;
      e.cnt = cnt;
      e.l   = mMatched ? 1'b1 : (confirming ? 1'(((age / BD) % 2)) : 1'b0);
      e.cyc = cyc;
      expQ.push_back(e);
      cyc++;
   endtask

   // Drive one cycle of inputs (called at a falling edge) and wait for the next falling edge
   task automatic applyStimulus(input bit f, input bit clr);
      similar_flag = f;
      clear = clr;
      modelStep(f, clr);
      @(negedge clk);
   endtask

   // One full sample period holding the flag; optional clear on the tick cycle
   task automatic sampleFlag(input bit f, input bit clrOnTick);
      for (int i = 0; i < SD; i++) applyStimulus(f, clrOnTick && (i == SD - 1));
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, "_matched"}, int'(matched), 0, cyc);
      checkVal({tag, "_pulse"}, int'(match_pulse), 0, cyc);
      checkVal({tag, "_cnt"}, int'(match_cnt), 0, cyc);
      checkVal({tag, "_led"}, int'(led), 0, cyc);
   endtask

   // Asynchronous reset between clock edges, checked immediately, released at a falling edge
   task automatic doReset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput(tag);
      expQ.delete();
      similar_flag = 1'b0;
      clear = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   // Scoreboard monitor: one expected entry per clock edge, compared just after the edge
   always @(posedge clk) begin
      #1;
      if (rst_n && expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkVal("matched", int'(matched), int'(e.m), e.cyc);
         checkVal("match_pulse", int'(match_pulse), int'(e.p), e.cyc);
         checkVal("match_cnt", int'(match_cnt), e.cnt, e.cyc);
         checkVal("led", int'(led), int'(e.l), e.cyc);
      end
   end

   initial begin
      bit f;
      int runLen;
      rst_n = 1'b0;
      similar_flag = 1'b0;
      clear = 1'b0;
      modelReset();
      @(negedge clk);
      doReset("reset");

      // Held flag: match on the third tick
      repeat (4) sampleFlag(1'b1, 1'b0);
      repeat (2) sampleFlag(1'b0, 1'b0);

      // Broken confirmation then a real one
      sampleFlag(1'b1, 1'b0); sampleFlag(1'b1, 1'b0); sampleFlag(1'b0, 1'b0);
      sampleFlag(1'b1, 1'b0); sampleFlag(1'b1, 1'b0); sampleFlag(1'b1, 1'b0);

      // Release bounce: 0,1 keeps match; 0,0 drops it
      sampleFlag(1'b0, 1'b0); sampleFlag(1'b1, 1'b0);
      sampleFlag(1'b0, 1'b0); sampleFlag(1'b0, 1'b0);

      // Saturation of the match counter
      for (int k = 0; k < 17; k++) begin
         repeat (CN) sampleFlag(1'b1, 1'b0);
         repeat (RN) sampleFlag(1'b0, 1'b0);
      end

      // Clear coinciding with a match pulse
      sampleFlag(1'b1, 1'b0); sampleFlag(1'b1, 1'b0); sampleFlag(1'b1, 1'b1);
      repeat (RN) sampleFlag(1'b0, 1'b0);

      // Randomized runs of flag values with occasional clears
      for (int k = 0; k < 60; k++) begin
         f = 1'($urandom_range(0, 1));
         runLen = int'($urandom_range(1, 4));
         for (int j = 0; j < runLen; j++) sampleFlag(f, $urandom_range(0, 15) == 0);
      end

      // Reset mid-confirmation, then mid-match, then a clean restart
      repeat (2) sampleFlag(1'b0, 1'b0);
      sampleFlag(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      doReset("rst_confirm");
      repeat (4) sampleFlag(1'b1, 1'b0);
      doReset("rst_matched");
      repeat (4) sampleFlag(1'b1, 1'b0);
      repeat (3) sampleFlag(1'b0, 1'b0);

      @(posedge clk);
      #2;
      checkVal("queue_drained", expQ.size(), 0, cyc);
      checkVal("pulses_modelled_nonzero", int'(nPulses > 20), 1, cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
